// File: rtl/remote_comm.sv
// Purpose : bench-side UART remote for the Knight's Tour robot; sends a 16-bit command as two 8N1 bytes, receives 8N1 response bytes.
// Latency : TX start bit 1 clk after an accepted send_cmd; cmd_sent 20*BAUD_DIV clks later; resp_rdy ~2 sync clks after the RX stop-bit centre.
// Backpressure: none; send_cmd is ignored while a command is in flight; no RX buffering, each good byte overwrites resp.
//
// Ports:
//   clk, rst          - rising-edge clock, asynchronous active-high reset
//   RX / TX           - serial response line in (async, idle high) / serial command line out (registered, idle high)
//   cmd, send_cmd     - 16-bit command and its one-cycle transmit request
//   cmd_sent          - high once both bytes of the last command have left the TX line
//   resp_rdy, resp    - one-cycle strobe and the last good received byte
module remote_comm #(
    parameter int BAUD_DIV = 2604
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RX,
    output logic        TX,
    input  logic [15:0] cmd,
    input  logic        send_cmd,
    output logic        cmd_sent,
    output logic        resp_rdy,
    output logic [7:0]  resp
);

    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] BIT_LAST  = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);

    // ------------------------------------------------------------------
    // Command transmitter
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {IDLE, SEND_HI, SEND_LO} tx_state_t;

    tx_state_t      tx_state;
    logic [15:0]    hold;
    logic [CW-1:0]  tx_cnt;
    logic [3:0]     tx_bit;     // 0 = start, 1..8 = data, 9 = stop
    logic [7:0]     tx_byte;

    assign tx_byte = (tx_state == SEND_HI) ? hold[15:8] : hold[7:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state <= IDLE;
            hold     <= '0;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            TX       <= 1'b1;
            cmd_sent <= 1'b0;
        end else begin
            case (tx_state)
                IDLE: begin
                    TX <= 1'b1;
                    if (send_cmd) begin
                        hold     <= cmd;
                        cmd_sent <= 1'b0;
                        tx_cnt   <= '0;
                        tx_bit   <= '0;
                        TX       <= 1'b0;
                        tx_state <= SEND_HI;
                    end
                end
                SEND_HI, SEND_LO: begin
                    if (tx_cnt != BIT_LAST) begin
                        tx_cnt <= tx_cnt + CW'(1);
                    end else begin
                        tx_cnt <= '0;
                        if (tx_bit == 4'd9) begin
                            tx_bit <= '0;
                            if (tx_state == SEND_HI) begin
                                // low byte's start bit follows the high byte's stop bit with no gap
                                tx_state <= SEND_LO;
                                TX       <= 1'b0;
                            end else begin
                                tx_state <= IDLE;
                                TX       <= 1'b1;
                                cmd_sent <= 1'b1;
                            end
                        end else begin
                            tx_bit <= tx_bit + 4'd1;
                            // next bit is data bit tx_bit (LSB first), or the stop bit after data bit 7
                            TX <= (tx_bit == 4'd8) ? 1'b1 : tx_byte[tx_bit[2:0]];
                        end
                    end
                end
                default: begin
                    tx_state <= IDLE;
                    TX       <= 1'b1;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Response receiver
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;

    rx_state_t      rx_state;
    logic           rx_meta, rx_sync, rx_prev;
    logic [CW-1:0]  rx_cnt;
    logic [2:0]     rx_bit;
    logic [7:0]     rx_shift;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta  <= 1'b1;
            rx_sync  <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= R_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            resp     <= '0;
            resp_rdy <= 1'b0;
        end else begin
            rx_meta  <= RX;
            rx_sync  <= rx_meta;
            rx_prev  <= rx_sync;
            resp_rdy <= 1'b0;
            case (rx_state)
                R_IDLE: begin
                    if (rx_prev && !rx_sync) begin
                        rx_cnt   <= '0;
                        rx_state <= R_START;
                    end
                end
                R_START: begin
                    // half a bit in: still low means a real start bit, high means a glitch
                    if (rx_cnt != HALF_LAST) begin
                        rx_cnt <= rx_cnt + CW'(1);
                    end else begin
                        rx_cnt   <= '0;
                        rx_bit   <= '0;
                        rx_state <= rx_sync ? R_IDLE : R_DATA;
                    end
                end
                R_DATA: begin
                    if (rx_cnt != BIT_LAST) begin
                        rx_cnt <= rx_cnt + CW'(1);
                    end else begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_sync, rx_shift[7:1]};
                        rx_bit   <= rx_bit + 3'd1;
                        if (rx_bit == 3'd7) rx_state <= R_STOP;
                    end
                end
                R_STOP: begin
                    if (rx_cnt != BIT_LAST) begin
                        rx_cnt <= rx_cnt + CW'(1);
                    end else begin
                        rx_cnt <= '0;
                        // a low stop bit is a framing error: drop the byte silently
                        if (rx_sync) begin
                            resp     <= rx_shift;
                            resp_rdy <= 1'b1;
                        end
                        rx_state <= R_IDLE;
                    end
                end
                default: rx_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_remote_comm.sv
// Purpose : self-checking bench for remote_comm against a waveform-level reference model.
// Latency : model predicts the TX line and cmd_sent every clock; responses are checked per resp_rdy strobe.
// Backpressure: n/a (bench drives send_cmd pulses and RX frames directly).
module tb_remote_comm;

    localparam int B = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_drv = 1'b1;
    logic        loop = 1'b0;
    logic        send_cmd = 1'b0;
    logic [15:0] cmd = '0;
    logic        RX, TX, cmd_sent, resp_rdy;
    logic [7:0]  resp;

    assign RX = loop ? TX : rx_drv;

    always #5 clk = ~clk;

    remote_comm #(.BAUD_DIV(B)) dut (
        .clk(clk), .rst(rst), .RX(RX), .TX(TX),
        .cmd(cmd), .send_cmd(send_cmd), .cmd_sent(cmd_sent),
        .resp_rdy(resp_rdy), .resp(resp)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int          tx_k = -1;          // clocks since the accepted send_cmd, -1 when idle
    logic [15:0] m_cmd = '0;
    logic        m_sent = 1'b0;
    logic [7:0]  m_resp = '0;
    logic [7:0]  exp_q[$];           // response bytes the robot side is owed
    int          sent_rises = 0;
    int          rdy_pulses = 0;

    // bit j (0..19) of the two back-to-back 8N1 frames of command c
    function automatic logic frame_bit(input logic [15:0] c, input int j);
        int b;
        logic [7:0] by;
        b  = j % 10;
        by = (j < 10) ? c[15:8] : c[7:0];
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return by[b-1];
    endfunction

    // Inputs only change just after a falling edge, so the values seen here are
    // those the DUT sampled on the preceding rising edge.
    initial begin : compare
        logic prev_sent;
        prev_sent = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                tx_k   = -1;
                m_sent = 1'b0;
                m_resp = '0;
                exp_q.delete();
            end else if (tx_k >= 0) begin
                tx_k++;
                if (tx_k == 20 * B) begin
                    tx_k   = -1;
                    m_sent = 1'b1;
                end
            end else if (send_cmd) begin
                m_cmd  = cmd;
                tx_k   = 0;
                m_sent = 1'b0;
            end
            chk("tx_line", TX, (tx_k < 0) ? 1'b1 : frame_bit(m_cmd, tx_k / B));
            chk("cmd_sent", cmd_sent, m_sent);
            if (resp_rdy === 1'b1) begin
                rdy_pulses++;
                if (exp_q.size() == 0) begin
                    chk("resp_rdy_spurious", resp_rdy, 1'b0);
                end else begin
                    m_resp = exp_q.pop_front();
                    chk("resp_byte", resp, m_resp);
                end
            end else begin
                chk("resp_hold", resp, m_resp);
            end
            if (cmd_sent === 1'b1 && prev_sent !== 1'b1) sent_rises++;
            prev_sent = cmd_sent;
        end
    end

    // ---------------- independent TX byte decoder ----------------
    logic [7:0] cap_q[$];

    initial begin : decoder
        logic [7:0] d;
        forever begin
            @(negedge clk);
            if (TX === 1'b0) begin
                repeat (B / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (B) @(negedge clk);
                    d[i] = TX;
                end
                repeat (B) @(negedge clk);
                if (TX === 1'b1) cap_q.push_back(d);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic pulse_cmd(input logic [15:0] c);
        @(negedge clk);
        #1 cmd = c; send_cmd = 1'b1;
        @(negedge clk);
        #1 send_cmd = 1'b0; cmd = 16'($urandom);
    endtask

    task automatic wait_sent(output int n);
        n = 0;
        while (cmd_sent !== 1'b1 && n < 22 * B) begin
            @(negedge clk);
            n++;
        end
        if (cmd_sent !== 1'b1) chk("cmd_sent_timeout", cmd_sent, 1'b1);
    endtask

    task automatic send_rx(input logic [7:0] d, input logic stop);
        if (stop) exp_q.push_back(d);
        #1 rx_drv = 1'b0;
        repeat (B) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            #1 rx_drv = d[i];
            repeat (B) @(negedge clk);
        end
        #1 rx_drv = stop;
        repeat (B) @(negedge clk);
    endtask

    task automatic rx_idle(input int n);
        #1 rx_drv = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic rx_glitch();
        #1 rx_drv = 1'b0;
        @(negedge clk);
        #1 rx_drv = 1'b1;
    endtask

    task automatic chk_cap(input logic [7:0] b0, input logic [7:0] b1);
        chk("tx_byte_count", cap_q.size(), 2);
        if (cap_q.size() >= 2) begin
            chk("tx_byte_hi", cap_q[0], b0);
            chk("tx_byte_lo", cap_q[1], b1);
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin : main
        int n, s0, p0;
        logic [15:0] c;
        logic [7:0] d1, d2;

        repeat (3) @(negedge clk);
        chk("rst_tx", TX, 1'b1);
        chk("rst_cmd_sent", cmd_sent, 1'b0);
        chk("rst_resp_rdy", resp_rdy, 1'b0);
        chk("rst_resp", resp, 8'h00);
        #3 rst = 1'b0;
        repeat (5) @(negedge clk);

        // 0x2000: frames 0x20 then 0x00, cmd_sent 20 bit-times after acceptance
        cap_q.delete();
        s0 = sent_rises;
        pulse_cmd(16'h2000);
        wait_sent(n);
        checks++;
        if (n < 20 * B || n > 20 * B + 2) begin
            errors++;
            $display("FAIL cmd_latency: got %0d clocks, expected %0d..%0d", n, 20 * B, 20 * B + 2);
        end
        repeat (4) @(negedge clk);
        chk_cap(8'h20, 8'h00);
        chk("sent_rises_2000", sent_rises - s0, 1);

        // robot sends ack 0xA5
        p0 = rdy_pulses;
        send_rx(8'hA5, 1'b1);
        rx_idle(B);
        chk("ack_pulses", rdy_pulses - p0, 1);
        chk("ack_resp", resp, 8'hA5);

        // loopback 0x12A5
        p0 = rdy_pulses;
        cap_q.delete();
        loop = 1'b1;
        exp_q.push_back(8'h12);
        exp_q.push_back(8'hA5);
        pulse_cmd(16'h12A5);
        wait_sent(n);
        repeat (4) @(negedge clk);
        loop = 1'b0;
        chk("loop_pulses", rdy_pulses - p0, 2);
        chk("loop_resp", resp, 8'hA5);
        chk_cap(8'h12, 8'hA5);

        // send_cmd during a transmission is ignored
        cap_q.delete();
        s0 = sent_rises;
        pulse_cmd(16'h1234);
        repeat (5 * B) @(negedge clk);
        pulse_cmd(16'hFFFF);
        wait_sent(n);
        repeat (2 * B) @(negedge clk);
        chk_cap(8'h12, 8'h34);
        chk("sent_rises_busy", sent_rises - s0, 1);

        // framing error: dropped, resp unchanged
        p0 = rdy_pulses;
        send_rx(8'h3C, 1'b0);
        rx_idle(2 * B);
        chk("ferr_pulses", rdy_pulses - p0, 0);
        chk("ferr_resp", resp, 8'hA5);

        // one-clock glitch is a false start; a good frame afterwards still lands
        p0 = rdy_pulses;
        rx_glitch();
        rx_idle(2 * B);
        chk("glitch_pulses", rdy_pulses - p0, 0);
        send_rx(8'h5A, 1'b1);
        rx_idle(B);
        chk("post_glitch_pulses", rdy_pulses - p0, 1);
        chk("post_glitch_resp", resp, 8'h5A);

        // randomized: loopback commands, or concurrent TX with back-to-back RX frames
        for (int it = 0; it < 6; it++) begin
            c  = 16'($urandom);
            d1 = 8'($urandom);
            d2 = 8'($urandom);
            cap_q.delete();
            if ($urandom_range(0, 1) == 0) begin
                loop = 1'b1;
                exp_q.push_back(c[15:8]);
                exp_q.push_back(c[7:0]);
                pulse_cmd(c);
                wait_sent(n);
                repeat (4) @(negedge clk);
                loop = 1'b0;
            end else begin
                fork
                    begin
                        pulse_cmd(c);
                        wait_sent(n);
                    end
                    begin
                        rx_idle($urandom_range(1, 3 * B));
                        send_rx(d1, 1'b1);
                        send_rx(d2, $urandom_range(0, 3) != 0);
                        rx_idle(B);
                        rx_glitch();
                        rx_idle(B);
                    end
                join
                rx_idle(4);
            end
            chk_cap(c[15:8], c[7:0]);
        end

        // asynchronous reset in the middle of a frame
        pulse_cmd(16'hBEEF);
        repeat (3 * B + 7) @(negedge clk);
        #3 rst = 1'b1;
        #1;
        chk("amid_rst_tx", TX, 1'b1);
        chk("amid_rst_cmd_sent", cmd_sent, 1'b0);
        chk("amid_rst_resp_rdy", resp_rdy, 1'b0);
        chk("amid_rst_resp", resp, 8'h00);
        repeat (2) @(negedge clk);
        #3 rst = 1'b0;
        rx_idle(12 * B);

        // recovery after reset
        cap_q.delete();
        pulse_cmd(16'h0F0F);
        wait_sent(n);
        repeat (4) @(negedge clk);
        chk_cap(8'h0F, 8'h0F);

        chk("resp_queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/remote_comm.md
Name: remote_comm

Overview:
- Bench-side "remote control" for the Knight's Tour robot.
- Accepts a 16-bit command and serialises it over a UART TX line as two 8N1 bytes, high byte first.
- Concurrently receives 8-bit response bytes (e.g. positive ack 0xA5) from the robot on a UART RX line.
- Sits between the test stimulus and the robot's RX/TX pins.

Parameters:
- BAUD_DIV, 2604: clocks per UART bit (50 MHz / 19200 baud); must be >= 16.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- RX  input  1  serial response line from robot; asynchronous, idle high.
- TX  output  1  serial command line to robot; idle high.
- cmd  input  16  command word; sampled on accepted send_cmd.
- send_cmd  input  1  one-cycle request to transmit cmd.
- cmd_sent  output  1  high once both bytes of the last command have been fully transmitted.
- resp_rdy  output  1  one-cycle pulse: new response byte valid on resp.
- resp  output  8  last received response byte.

Behaviour:
- Reset (async, rst=1): TX=1, cmd_sent=0, resp_rdy=0, resp=0x00, all FSMs idle, counters cleared.
- Command path FSM, states IDLE, SEND_HI, SEND_LO:
  - IDLE + send_cmd=1: latch cmd into a 16-bit holding register, clear cmd_sent next cycle, go to SEND_HI.
  - send_cmd while not IDLE is ignored; the latched value is not disturbed.
  - SEND_HI transmits cmd[15:8]; when its stop bit completes, go to SEND_LO.
  - SEND_LO transmits cmd[7:0], starting on the clock after the high-byte stop bit ends (no idle gap).
  - When the low-byte stop bit completes: set cmd_sent=1, return to IDLE.
  - cmd_sent holds until the next accepted send_cmd.
- UART TX framing: start bit 0, 8 data bits LSB first, stop bit 1; each bit held exactly BAUD_DIV clocks.
  - One frame = 10*BAUD_DIV clocks; full command = 20*BAUD_DIV clocks.
  - TX is registered (glitch-free) and driven high whenever idle.
- Latency: TX falls to the start bit 1 clock after send_cmd is accepted. cmd_sent rises 20*BAUD_DIV + 1 (±1) clocks after send_cmd.
- UART RX:
  - RX is double-flop synchronised before use.
  - Idle until a synchronised falling edge is seen, then wait BAUD_DIV/2 clocks and re-sample.
  - If the line is high at that point (false start), return to idle.
  - Otherwise sample 8 data bits at BAUD_DIV intervals (bit centres), shifting LSB first, then sample the stop bit.
  - Stop bit = 1: load resp with the byte and pulse resp_rdy high for exactly one clock.
  - Stop bit = 0 (framing error): discard the byte; resp and resp_rdy are unchanged.
  - The receiver accepts back-to-back frames: the next start edge is detected immediately after the stop-bit sample.
- TX and RX paths are fully independent; simultaneous transmit and receive must work.
- Reset mid-operation: both paths abort immediately to the reset state; TX returns high at once.
- Counters are sized to hold BAUD_DIV-1 without overflow; bit counters wrap 0..9.

Test Plan:
- Reset: assert rst mid-frame -> TX=1, cmd_sent=0, resp_rdy=0, resp=0x00 immediately, without waiting for a clock edge.
- Send cmd=0x2000 with BAUD_DIV=2604 -> TX frames 0x20 then 0x00. Bit sequence 0,0000 0100,1 then 0,0000 0000,1, each bit 2604 clocks. cmd_sent rises ~52080 clocks after send_cmd.
- Loop TX to RX, send 0x12A5 -> resp_rdy pulses twice (1 clock each); resp=0x12 after the first, 0xA5 after the second.
- Robot-side model sends 0xA5 on RX -> one resp_rdy pulse; resp==0xA5 holds afterwards.
- Pulse send_cmd with cmd=0xFFFF during a transmission of 0x1234 -> only 0x12, 0x34 appear on TX; cmd_sent rises once.
- RX frame with stop bit 0 -> no resp_rdy and resp unchanged. A 1-clock low glitch on RX -> ignored as a false start.
